// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock-enable divider.
//
// Each channel divides clk by a runtime divisor D and produces a registered
// square-wave strobe (div_out) plus a one-cycle tick at the start of each
// period. No derived clock nets are produced; everything is a strobe in the
// clk domain.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high reset
//   cfg_valid  - divisor write strobe
//   cfg_chan   - target channel of the write (out-of-range values ignored)
//   cfg_div    - new divisor: 0 = off, 1 = constant high, >=2 = divide by D
//   sync       - restarts the phase of every channel
//   and_mask   - channels combined into Y
//   div_out    - registered divided wave per channel
//   tick       - registered one-cycle period-start pulse per channel
//   Y          - AND of the masked div_out bits (0 when the mask is empty)
module clk_div_prog #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                sync,
  input  logic [CHANNELS-1:0] and_mask,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick,
  output logic                Y
);

  logic [WIDTH-1:0]    r_cnt    [CHANNELS];
  logic [WIDTH-1:0]    r_d_act  [CHANNELS];
  logic [WIDTH-1:0]    r_d_pend [CHANNELS];
  logic [CHANNELS-1:0] r_div_out;
  logic [CHANNELS-1:0] r_tick;

  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_last;
  logic [CHANNELS-1:0] w_wrap;
  logic [WIDTH-1:0]    w_d_next [CHANNELS];

  // Per-channel write select, end-of-period detect and wrap (ratio-swap) edge.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      // k < CHANNELS always, so an out-of-range cfg_chan never matches.
      w_sel[k]    = cfg_valid && (cfg_chan == CW'(k));
      // A write on the wrap edge bypasses d_pend straight into d_act.
      w_d_next[k] = w_sel[k] ? cfg_div : r_d_pend[k];
      w_last[k]   = (r_d_act[k] >= WIDTH'(2)) &&
                    (r_cnt[k] == (r_d_act[k] - WIDTH'(1)));
      w_wrap[k]   = sync || w_last[k] || (r_d_act[k] <= WIDTH'(1));
    end
  end

  // Counters, divisor registers and registered output decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_cnt[k]    <= '0;
        // Default ratios 2, 4, 8, 16, ... keep the old cascaded behaviour.
        r_d_act[k]  <= WIDTH'(1) << (k + 1);
        r_d_pend[k] <= WIDTH'(1) << (k + 1);
      end
      r_div_out <= '0;
      r_tick    <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sync || (r_d_act[k] <= WIDTH'(1)) || w_last[k]) begin
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + WIDTH'(1);
        end

        r_d_pend[k] <= w_d_next[k];
        // Ratio only changes on a period boundary, so no runt pulses.
        if (w_wrap[k]) begin
          r_d_act[k] <= w_d_next[k];
        end else begin
          r_d_act[k] <= r_d_act[k];
        end

        // Decode uses the pre-edge cnt/d_act, even on a sync edge.
        if (r_d_act[k] >= WIDTH'(2)) begin
          r_div_out[k] <= (r_cnt[k] < (r_d_act[k] >> 1));
          r_tick[k]    <= (r_cnt[k] == '0);
        end else begin
          // D = 1 -> both high; D = 0 -> both low.
          r_div_out[k] <= r_d_act[k][0];
          r_tick[k]    <= r_d_act[k][0];
        end
      end
    end
  end

  assign div_out = r_div_out;
  assign tick    = r_tick;
  assign Y       = (|and_mask) & (&(r_div_out | ~and_mask));

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog.
// A 4-channel instance carries the main scenarios; a 6-channel instance
// provides cfg_chan codes (6, 7) that lie outside the channel range.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_div;
  logic       sync;
  logic [3:0] and_mask;
  logic [3:0] div_out;
  logic [3:0] tick;
  logic       y;

  logic [2:0] cfg_chan6;
  logic [5:0] and_mask6;
  logic [5:0] div_out6;
  logic [5:0] tick6;
  logic       y6;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_prog #(.WIDTH(8), .CHANNELS(4)) u_dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .sync(sync), .and_mask(and_mask),
    .div_out(div_out), .tick(tick), .Y(y)
  );

  clk_div_prog #(.WIDTH(8), .CHANNELS(6)) u_dut6 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_chan(cfg_chan6),
    .cfg_div(cfg_div), .sync(sync), .and_mask(and_mask6),
    .div_out(div_out6), .tick(tick6), .Y(y6)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    sync      = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reset state, default ratios 2/4/8/16 and the masked AND on Y.
  task automatic test_reset();
    logic [3:0] ed;
    logic [3:0] et;
    logic       ey;
    int         d;
    int         c;
    reset    = 1'b1;
    and_mask = 4'b0101;
    step();
    n_cmp++;
    if (div_out !== 4'b0000) begin
      $display("FAIL reset_div: got %b want 0000", div_out); n_bad++;
    end
    n_cmp++;
    if (tick !== 4'b0000) begin
      $display("FAIL reset_tick: got %b want 0000", tick); n_bad++;
    end
    n_cmp++;
    if (y !== 1'b0) begin
      $display("FAIL reset_y: got %b want 0", y); n_bad++;
    end
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      and_mask = (i <= 16) ? 4'b0101 : ((i <= 24) ? 4'b1111 : 4'b0000);
      step();
      for (int k = 0; k < 4; k++) begin
        d     = 2 << k;
        c     = (i - 1) % d;
        ed[k] = (c < d / 2);
        et[k] = (c == 0);
      end
      ey = (and_mask != 4'b0000) && ((ed | ~and_mask) == 4'b1111);
      n_cmp++;
      if (div_out !== ed) begin
        $display("FAIL default_div edge %0d: got %b want %b", i, div_out, ed); n_bad++;
      end
      n_cmp++;
      if (tick !== et) begin
        $display("FAIL default_tick edge %0d: got %b want %b", i, tick, et); n_bad++;
      end
      n_cmp++;
      if (y !== ey) begin
        $display("FAIL default_y edge %0d mask %b: got %b want %b", i, and_mask, y, ey); n_bad++;
      end
    end
  endtask

  // D=5 written to ch0 mid-period: old period finishes, then 1,1,0,0,0.
  task automatic test_prog_d5();
    do_reset();
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if ({div_out[0], tick[0]} !== 2'b11) begin
      $display("FAIL d5_e1: got %b%b want 11", div_out[0], tick[0]); n_bad++;
    end
    step();
    n_cmp++;
    if ({div_out[0], tick[0]} !== 2'b00) begin
      $display("FAIL d5_e2: got %b%b want 00", div_out[0], tick[0]); n_bad++;
    end
    for (int j = 0; j < 15; j++) begin
      step();
      n_cmp++;
      if (div_out[0] !== ((j % 5) < 2)) begin
        $display("FAIL d5_div j=%0d: got %b want %b", j, div_out[0], ((j % 5) < 2)); n_bad++;
      end
      n_cmp++;
      if (tick[0] !== ((j % 5) == 0)) begin
        $display("FAIL d5_tick j=%0d: got %b want %b", j, tick[0], ((j % 5) == 0)); n_bad++;
      end
    end
  endtask

  // ch1: D=0 turns it off after its wrap, then D=1 holds both outputs high.
  task automatic test_disable();
    do_reset();
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if ({div_out[1], tick[1]} !== 2'b11) begin
      $display("FAIL off_e1: got %b%b want 11", div_out[1], tick[1]); n_bad++;
    end
    for (int e = 2; e <= 12; e++) begin
      step();
      n_cmp++;
      if ({div_out[1], tick[1]} !== {(e == 2), 1'b0}) begin
        $display("FAIL off edge %0d: got %b%b want %b0", e, div_out[1], tick[1], (e == 2)); n_bad++;
      end
    end
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if ({div_out[1], tick[1]} !== 2'b00) begin
      $display("FAIL on1_write_edge: got %b%b want 00", div_out[1], tick[1]); n_bad++;
    end
    for (int e = 0; e < 8; e++) begin
      step();
      n_cmp++;
      if ({div_out[1], tick[1]} !== 2'b11) begin
        $display("FAIL on1 edge %0d: got %b%b want 11", e, div_out[1], tick[1]); n_bad++;
      end
    end
  endtask

  // ch2=6, ch3=3 then sync: all channels restart aligned at the new ratios.
  task automatic test_sync();
    int         dv [4];
    logic [3:0] ed;
    logic [3:0] et;
    int         c;
    dv[0] = 2; dv[1] = 4; dv[2] = 6; dv[3] = 3;
    do_reset();
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd6;
    step();
    cfg_chan = 2'd3; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    sync      = 1'b1;
    step();
    sync = 1'b0;
    n_cmp++;
    if (div_out !== 4'b1101) begin
      $display("FAIL sync_edge_div: got %b want 1101", div_out); n_bad++;
    end
    n_cmp++;
    if (tick !== 4'b0001) begin
      $display("FAIL sync_edge_tick: got %b want 0001", tick); n_bad++;
    end
    for (int j = 0; j < 18; j++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        c     = j % dv[k];
        ed[k] = (c < dv[k] / 2);
        et[k] = (c == 0);
      end
      n_cmp++;
      if (div_out !== ed) begin
        $display("FAIL sync_div j=%0d: got %b want %b", j, div_out, ed); n_bad++;
      end
      n_cmp++;
      if (tick !== et) begin
        $display("FAIL sync_tick j=%0d: got %b want %b", j, tick, et); n_bad++;
      end
    end
  endtask

  // Write D=10 to ch3 exactly on its wrap edge: bypass, no 16-cycle period.
  task automatic test_wrap_bypass();
    do_reset();
    repeat (15) step();
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd10;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if ({div_out[3], tick[3]} !== 2'b00) begin
      $display("FAIL bypass_wrap_edge: got %b%b want 00", div_out[3], tick[3]); n_bad++;
    end
    for (int j = 0; j < 30; j++) begin
      step();
      n_cmp++;
      if (div_out[3] !== ((j % 10) < 5)) begin
        $display("FAIL bypass_div j=%0d: got %b want %b", j, div_out[3], ((j % 10) < 5)); n_bad++;
      end
      n_cmp++;
      if (tick[3] !== ((j % 10) == 0)) begin
        $display("FAIL bypass_tick j=%0d: got %b want %b", j, tick[3], ((j % 10) == 0)); n_bad++;
      end
    end
  endtask

  // Reset mid-period discards active and pending programming.
  task automatic test_reset_mid();
    logic [3:0] ed;
    logic [3:0] et;
    int         d;
    int         c;
    do_reset();
    and_mask  = 4'b1111;
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd7;
    step();
    reset = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd3;
    step();
    reset = 1'b0; cfg_valid = 1'b0;
    n_cmp++;
    if ({div_out, tick, y} !== 9'b0) begin
      $display("FAIL midrst_edge: got div %b tick %b y %b want all 0", div_out, tick, y); n_bad++;
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        d     = 2 << k;
        c     = (i - 1) % d;
        ed[k] = (c < d / 2);
        et[k] = (c == 0);
      end
      n_cmp++;
      if (div_out !== ed) begin
        $display("FAIL midrst_div edge %0d: got %b want %b", i, div_out, ed); n_bad++;
      end
      n_cmp++;
      if (tick !== et) begin
        $display("FAIL midrst_tick edge %0d: got %b want %b", i, tick, et); n_bad++;
      end
    end
  endtask

  // 6-channel instance: cfg_chan 6 and 7 must not touch any channel.
  task automatic test_out_of_range();
    logic [5:0] ed;
    logic [5:0] et;
    int         d;
    int         c;
    do_reset();
    cfg_div = 8'd3;
    for (int i = 1; i <= 70; i++) begin
      cfg_valid = (i <= 2);
      cfg_chan6 = (i == 1) ? 3'd6 : 3'd7;
      step();
      for (int k = 0; k < 6; k++) begin
        d     = 2 << k;
        c     = (i - 1) % d;
        ed[k] = (c < d / 2);
        et[k] = (c == 0);
      end
      n_cmp++;
      if (div_out6 !== ed) begin
        $display("FAIL oor_div edge %0d: got %b want %b", i, div_out6, ed); n_bad++;
      end
      n_cmp++;
      if (tick6 !== et) begin
        $display("FAIL oor_tick edge %0d: got %b want %b", i, tick6, et); n_bad++;
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = 2'd0;
    cfg_div   = 8'd0;
    sync      = 1'b0;
    and_mask  = 4'b0000;
    cfg_chan6 = 3'd0;
    and_mask6 = 6'b000000;
    test_reset();
    test_prog_d5();
    test_disable();
    test_sync();
    test_wrap_bypass();
    test_reset_mid();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
